// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: formats a UART frame and paces load/shift pulses for an 11-bit transmit shift register
module uart_tx_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  baud,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  input  logic [7:0]  data,
  input  logic        write,
  output logic        ld,
  output logic        sh,
  output logic [10:0] d_out,
  output logic        tx_rdy,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;
  logic [3:0] baud_r;
  logic [18:0] div, cnt;
  logic [3:0] bit_cnt;
  logic hit, accept, par, b9, b10;
  assign accept = state == IDLE && write;
  assign hit = state == SHIFT && cnt == div - 19'd1;
  assign par = ^(eight ? data : {1'b0, data[6:0]}) ^ ohel;
  assign b9 = eight ? data[7] : (pen ? par : 1'b1);
  assign b10 = eight && pen ? par : 1'b1;
  // clocks per bit for the latched baud code at 100 MHz
  always_comb begin
    case (baud_r)
      4'd0:    div = 19'd333333;
      4'd1:    div = 19'd83333;
      4'd2:    div = 19'd41667;
      4'd3:    div = 19'd20833;
      4'd4:    div = 19'd10417;
      4'd5:    div = 19'd5208;
      4'd6:    div = 19'd2604;
      4'd7:    div = 19'd1736;
      4'd8:    div = 19'd868;
      4'd9:    div = 19'd434;
      4'd10:   div = 19'd217;
      default: div = 19'd109;
    endcase
  end
  // next state: load on accepted write, shift until the 11th bit has gone out
  always_comb begin
    state_nx = state;
    if (accept) state_nx = LOAD;
    else if (state == LOAD) state_nx = SHIFT;
    else if (state == SHIFT && bit_cnt == 4'd11) state_nx = IDLE;
  end
  // state, counters, latched config and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      baud_r  <= '0;
      ld      <= 1'b0;
      sh      <= 1'b0;
      d_out   <= 11'h7FF;
      tx_rdy  <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= (state == IDLE || hit) ? '0 : cnt + 19'd1;
      bit_cnt <= state == IDLE ? '0 : bit_cnt + {3'b0, hit};
      baud_r  <= accept ? baud : baud_r;
      d_out   <= accept ? {b10, b9, data[6:0], 2'b01} : d_out;
      ld      <= state_nx == LOAD;
      sh      <= hit;
      tx_rdy  <= state_nx == IDLE;
      busy    <= state_nx != IDLE;
      overrun <= write && state != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: cycle-by-cycle check of uart_tx_ctrl against a timing/frame model plus directed literal checks
module tb_uart_tx_ctrl;
  logic clk = 0, rst = 1;
  logic [3:0] baud = 0;
  logic eight = 0, pen = 0, ohel = 0, write = 0;
  logic [7:0] data = 0;
  logic ld, sh, tx_rdy, busy, overrun;
  logic [10:0] d_out;
  int tests = 0, fails = 0;
  bit chk_en = 0;

  uart_tx_ctrl dut (.clk(clk), .rst(rst), .baud(baud), .eight(eight), .pen(pen), .ohel(ohel),
    .data(data), .write(write), .ld(ld), .sh(sh), .d_out(d_out), .tx_rdy(tx_rdy), .busy(busy),
    .overrun(overrun));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  // model: one frame described by its write cycle, divisor and frame word
  int dtab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109,
                    109, 109, 109, 109};
  longint cyc = 0, n_w = 0, ov_c = -1;
  bit active = 0;
  int dv = 1;
  logic [10:0] exp_d = 11'h7FF;

  function automatic logic [10:0] frame(input logic [7:0] d, input logic e, input logic p, input logic o);
    int ones;
    logic pr, b9, b10;
    ones = e ? $countones(d) : $countones(d[6:0]);
    pr = (ones % 2 == 1) ^ o;
    if (e) begin b9 = d[7]; b10 = p ? pr : 1'b1; end
    else begin b9 = p ? pr : 1'b1; b10 = 1'b1; end
    return {b10, b9, d[6:0], 1'b0, 1'b1};
  endfunction

  function automatic bit busy_at(input longint c);
    return active && c >= n_w + 1 && c <= n_w + 1 + 11 * dv;
  endfunction

  function automatic bit sh_at(input longint c);
    longint r;
    r = c - n_w - 1;
    return active && r > 0 && r % dv == 0 && r / dv <= 11;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 0;
      exp_d = 11'h7FF;
      ov_c = -1;
    end else if (write) begin
      if (busy_at(cyc)) ov_c = cyc + 1;
      else begin
        active = 1;
        n_w = cyc;
        dv = dtab[baud];
        exp_d = frame(data, eight, pen, ohel);
      end
    end
    if (clk) cyc++;
  end

  always @(negedge clk) if (chk_en) begin
    chk("ld", ld, active && cyc == n_w + 1);
    chk("sh", sh, sh_at(cyc));
    chk("d_out", d_out, exp_d);
    chk("tx_rdy", tx_rdy, !busy_at(cyc));
    chk("busy", busy, busy_at(cyc));
    chk("overrun", overrun, cyc == ov_c);
  end

  // called at a negedge; returns at the negedge of the ld cycle
  task automatic do_write(input logic [3:0] b, input logic e, input logic p, input logic o, input logic [7:0] d);
    baud = b; eight = e; pen = p; ohel = o; data = d; write = 1;
    @(posedge clk);
    #1 write = 0;
    @(negedge clk);
  endtask

  // kind 1: change config, 2: assert reset, 3: overlapping write -- each at the poke_at-th sh
  task automatic observe(input int poke_at, input int kind, output int n, output int gmin, output int gmax, output int roff);
    longint t0, last;
    int gap;
    n = 0; gmin = 1 << 30; gmax = 0; roff = -1; t0 = cyc; last = cyc;
    for (int i = 0; i < 30000 && roff < 0; i++) begin
      @(negedge clk);
      if (kind == 3 && write) begin
        write = 0;
        chk("overrun_pulse", overrun, 1);
      end
      if (sh) begin
        n++;
        gap = int'(cyc - last);
        last = cyc;
        if (gap < gmin) gmin = gap;
        if (gap > gmax) gmax = gap;
        if (n == poke_at) begin
          if (kind == 1) begin baud = 0; eight = ~eight; pen = ~pen; ohel = ~ohel; end
          if (kind == 2) begin #1 rst = 1; return; end
          if (kind == 3) begin data = 8'hAA; write = 1; end
        end
      end
      if (tx_rdy) roff = int'(cyc - t0);
    end
    if (roff < 0) chk("frame_timeout", 0, 1);
  endtask

  int n, gmin, gmax, roff;

  task automatic frame_test(input string nm, input logic [3:0] b, input logic e, input logic p, input logic o,
                            input logic [7:0] d, input logic [10:0] want, input int spacing);
    do_write(b, e, p, o, d);
    chk({nm, "_ld"}, ld, 1);
    chk({nm, "_d_out"}, d_out, want);
    observe(0, 0, n, gmin, gmax, roff);
    chk({nm, "_nsh"}, n, 11);
    chk({nm, "_gap_min"}, gmin, spacing);
    chk({nm, "_gap_max"}, gmax, spacing);
    chk({nm, "_rdy"}, roff, 11 * spacing + 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_d_out", d_out, 11'h7FF);
    chk("rst_tx_rdy", tx_rdy, 1);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    frame_test("8n", 4'd8, 1, 0, 0, 8'h55, 11'h555, 868);
    frame_test("8e", 4'd11, 1, 1, 0, 8'h55, 11'h155, 109);
    frame_test("8o", 4'd11, 1, 1, 1, 8'h55, 11'h555, 109);
    frame_test("7o", 4'd11, 0, 1, 1, 8'h03, 11'h60D, 109);
    frame_test("7n", 4'd11, 0, 0, 0, 8'h83, 11'h60D, 109);
    do_write(4'd10, 1, 0, 0, 8'h55);
    chk("ovr_d_out", d_out, 11'h555);
    observe(5, 3, n, gmin, gmax, roff);
    chk("ovr_nsh", n, 11);
    chk("ovr_gap_min", gmin, 217);
    chk("ovr_gap_max", gmax, 217);
    chk("ovr_d_out_end", d_out, 11'h555);
    do_write(4'd14, 1, 0, 0, 8'h0F);
    observe(2, 1, n, gmin, gmax, roff);
    chk("baud_nsh", n, 11);
    chk("baud_gap_min", gmin, 109);
    chk("baud_gap_max", gmax, 109);
    do_write(4'd8, 1, 0, 0, 8'h0F);
    observe(3, 2, n, gmin, gmax, roff);
    @(negedge clk);
    chk("mid_rst_ld", ld, 0);
    chk("mid_rst_sh", sh, 0);
    chk("mid_rst_d_out", d_out, 11'h7FF);
    chk("mid_rst_tx_rdy", tx_rdy, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    n = 0;
    repeat (20000) begin
      @(negedge clk);
      if (sh) n++;
    end
    chk("post_rst_nsh", n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sits directly upstream of the 11-bit transmit shift register. It accepts a byte on a write strobe and formats the frame per the word-length and parity configuration. It then drives the register's parallel-load data, load pulse and shift pulses at the selected baud rate, and reports ready/busy back to the host bus.

## Interface
- No parameters. The baud divisor table assumes a fixed 100 MHz clk.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- baud  in  4  baud-rate select code; sampled on an accepted write.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits; sampled on an accepted write.
- pen  in  1  parity enable; sampled on an accepted write.
- ohel  in  1  parity sense: 1 = odd, 0 = even; sampled on an accepted write.
- data  in  8  byte to transmit; sampled on an accepted write.
- write  in  1  one-cycle write strobe.
- ld  out  1  one-cycle parallel-load pulse to the shift register.
- sh  out  1  one-cycle shift pulse to the shift register.
- d_out  out  11  frame word for the shift register's parallel input. Registered and held between loads.
- tx_rdy  out  1  1 = a write will be accepted.
- busy  out  1  1 = a frame is in progress (inverse of tx_rdy).
- overrun  out  1  one-cycle pulse when a write arrives while busy.

## Operation
- Divisor table, divisor = clocks per bit:
  - 0 = 333333, 1 = 83333, 2 = 41667, 3 = 20833, 4 = 10417, 5 = 5208
  - 6 = 2604, 7 = 1736, 8 = 868, 9 = 434, 10 = 217, 11 = 109
  - 12–15 = 109
  - The baud counter is 19 bits wide.
- Frame word: d_out = {b10, b9, data[6:0], 1'b0, 1'b1}. The shift register sends LSB first: an idle bit, then the start bit, then data, then b9, then b10. The shift register's serial input is tied to 1 and supplies the trailing stop bit.
- b10/b9 by mode:
  - 8-bit, no parity: b9 = data[7], b10 = 1.
  - 8-bit, parity: b9 = data[7], b10 = parity over data[7:0].
  - 7-bit, no parity: b9 = 1, b10 = 1.
  - 7-bit, parity: b9 = parity over data[6:0], b10 = 1.
  - In 7-bit modes, data[7] is ignored.
- Parity value: even parity = XOR of the data bits; odd parity = XNOR of the data bits.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: tx_rdy = 1. When write = 1, latch data/baud/eight/pen/ohel, compute d_out, go to LOAD.
  - LOAD: ld = 1 for exactly one cycle; clear the baud counter and bit counter; go to SHIFT.
  - SHIFT: the baud counter increments every cycle. When it reaches divisor − 1: pulse sh, reset the counter to 0, and increment the bit counter. After the 11th sh pulse, go to IDLE.
- Write while not in IDLE: data is ignored, latched configuration is unchanged, and overrun pulses for one cycle.
- Changing baud/eight/pen/ohel mid-frame has no effect; only the latched copies are used.

## Timing
- Reset values: ld = 0, sh = 0, d_out = 11'h7FF, tx_rdy = 1, busy = 0, overrun = 0. Both counters are 0 and the FSM is in IDLE.
- All outputs are registered.
- Accepted write in cycle N:
  - ld = 1 and d_out is valid in cycle N+1.
  - tx_rdy = 0 and busy = 1 from cycle N+1.
- The k-th sh pulse occurs in cycle N+1 + k·divisor, for k = 1..11.
- tx_rdy returns to 1 in the cycle after the 11th sh.
- A write in that first ready cycle is accepted. The next frame's leading idle bit guarantees at least one stop bit-time between frames.
- ld and sh are never asserted in the same cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous), and no further sh pulses occur after rst deasserts.
- overrun is asserted in the cycle after the offending write.

## Test plan
- Reset: assert rst mid-frame (after the 3rd sh) -> all outputs at reset values; no sh for 20000 cycles after release.
- 8N, baud = 8, data = 0x55 -> d_out = 0x555; ld 1 cycle after write; sh pulses exactly 868 cycles apart, 11 total; tx_rdy = 1 at ld + 9549.
- 8-bit parity, data = 0x55: even (ohel = 0) -> d_out = 0x155; odd (ohel = 1) -> d_out = 0x555.
- 7-bit odd parity, data = 0x03 -> d_out = 0x60D. 7N, data = 0x83 -> d_out = 0x60D (data[7] ignored).
- Write at the 5th sh with data = 0xAA -> overrun pulse; d_out and sh spacing unchanged; only 11 sh total.
- baud = 14 -> sh spacing 109 cycles. Change baud to 0 mid-frame -> spacing stays 109 until the frame ends.
